// File: rtl/register_file.sv
// Byte-addressable register file with paired 2*DATASIZE load/increment/decrement operations.
// Optional macro REGFILE_BYPASS_EN forwards next-edge write values to every read port.
module register_file #(
   parameter int DATASIZE = 8,
   parameter int REGCOUNT = 8,
   parameter int ADDRSIZE = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_enb,
   input  logic [ADDRSIZE-1:0]     wr_addr,
   input  logic [DATASIZE-1:0]     wr_data,
   input  logic                    pr_enb,
   input  logic [ADDRSIZE-2:0]     pr_addr,
   input  logic [1:0]              pr_op,
   input  logic [2*DATASIZE-1:0]   pr_data,
   input  logic [ADDRSIZE-1:0]     rd_addr_a,
   input  logic [ADDRSIZE-1:0]     rd_addr_b,
   output logic [DATASIZE-1:0]     rd_data_a,
   output logic [DATASIZE-1:0]     rd_data_b,
   input  logic [ADDRSIZE-2:0]     rp_addr,
   output logic [2*DATASIZE-1:0]   rp_data
);

   localparam int PAIRSIZE = 2 * DATASIZE;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_HOLD = 2'b11
   } pair_op_e;

   logic [DATASIZE-1:0] r_regs [REGCOUNT];
   logic [DATASIZE-1:0] w_next [REGCOUNT];
   logic [DATASIZE-1:0] w_view [REGCOUNT];

   logic [ADDRSIZE-1:0] w_pr_hi_idx;
   logic [ADDRSIZE-1:0] w_pr_lo_idx;
   logic [ADDRSIZE-1:0] w_rp_hi_idx;
   logic [ADDRSIZE-1:0] w_rp_lo_idx;
   logic [PAIRSIZE-1:0] w_pair_cur;
   logic [PAIRSIZE-1:0] w_pair_new;
   pair_op_e            w_op;

   // Pair p occupies reg[2p] (high byte) and reg[2p+1] (low byte).
   assign w_pr_hi_idx = {pr_addr, 1'b0};
   assign w_pr_lo_idx = {pr_addr, 1'b1};
   assign w_rp_hi_idx = {rp_addr, 1'b0};
   assign w_rp_lo_idx = {rp_addr, 1'b1};
   assign w_op        = pair_op_e'(pr_op);
   assign w_pair_cur  = {r_regs[w_pr_hi_idx], r_regs[w_pr_lo_idx]};

   // Full-width add/subtract carries/borrows across both bytes in one cycle.
   always_comb begin
      // NOTE: default assigned first so every path drives the signal and no latch is inferred.
      w_pair_new = w_pair_cur;
      case (w_op)
         OP_LOAD: w_pair_new = pr_data;
         OP_INC:  w_pair_new = w_pair_cur + PAIRSIZE'(1);
         OP_DEC:  w_pair_new = w_pair_cur - PAIRSIZE'(1);
         OP_HOLD: w_pair_new = w_pair_cur;
         default: w_pair_new = w_pair_cur;
      endcase
   end

   // Pair update is applied after the byte write so it wins on a shared register.
   always_comb begin
      w_next = r_regs;
      if (wr_enb) begin
         w_next[wr_addr] = wr_data;
      end
      if (pr_enb) begin
         w_next[w_pr_hi_idx] = w_pair_new[PAIRSIZE-1:DATASIZE];
         w_next[w_pr_lo_idx] = w_pair_new[DATASIZE-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: storage is a flop array, so every entry is cleared; this would not map onto a RAM macro.
         for (int i = 0; i < REGCOUNT; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         r_regs <= w_next;
      end
   end

   always_comb begin
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < REGCOUNT; i++) begin
         w_view[i] = rst ? '0 : w_next[i];
      end
`else
      w_view = r_regs;
`endif
   end

   assign rd_data_a = w_view[rd_addr_a];
   assign rd_data_b = w_view[rd_addr_b];
   assign rp_data   = {w_view[w_rp_hi_idx], w_view[w_rp_lo_idx]};

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected reads are queued from a reference model and
// popped when the corresponding read port is sampled.
`timescale 1ns/1ps
module tb_register_file;

   localparam int DW = 8;
   localparam int RC = 8;
   localparam int AW = 3;

   localparam int PORT_A    = 0;
   localparam int PORT_B    = 1;
   localparam int PORT_PAIR = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_enb;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          pr_enb;
   logic [AW-2:0] pr_addr;
   logic [1:0]    pr_op;
   logic [2*DW-1:0] pr_data;
   logic [AW-1:0] rd_addr_a;
   logic [AW-1:0] rd_addr_b;
   logic [DW-1:0] rd_data_a;
   logic [DW-1:0] rd_data_b;
   logic [AW-2:0] rp_addr;
   logic [2*DW-1:0] rp_data;

   always #5 clk = ~clk;

   register_file #(.DATASIZE(DW), .REGCOUNT(RC), .ADDRSIZE(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_enb    (wr_enb),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .pr_enb    (pr_enb),
      .pr_addr   (pr_addr),
      .pr_op     (pr_op),
      .pr_data   (pr_data),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .rp_addr   (rp_addr),
      .rp_data   (rp_data)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      string         tag;
      int            port;
      logic [AW-1:0] addr;
      logic [15:0]   exp;
   } exp_t;

   exp_t        sb[$];
   logic [DW-1:0] mdl [RC];

   task automatic push_val(input string tag, input int port, input logic [AW-1:0] addr,
                           input logic [15:0] exp);
      exp_t e;
      e.tag  = tag;
      e.port = port;
      e.addr = addr;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   // Expected value taken from the reference model at push time.
   task automatic push_mdl(input string tag, input int port, input logic [AW-1:0] addr);
      int p;
      p = int'(addr);
      if (port == PORT_PAIR) push_val(tag, port, addr, {mdl[2*p], mdl[2*p+1]});
      else                   push_val(tag, port, addr, {8'h00, mdl[p]});
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.port)
            PORT_A: begin rd_addr_a = e.addr; #1; check(e.tag, {8'h00, rd_data_a}, e.exp); end
            PORT_B: begin rd_addr_b = e.addr; #1; check(e.tag, {8'h00, rd_data_b}, e.exp); end
            default: begin rp_addr = e.addr[AW-2:0]; #1; check(e.tag, rp_data, e.exp); end
         endcase
      end
   endtask

   // Reference behaviour for the inputs currently driven, applied at the coming edge.
   task automatic model_step();
      logic [DW-1:0]   nxt [RC];
      logic [2*DW-1:0] cur;
      logic [2*DW-1:0] nw;
      int              p;
      if (rst) begin
         for (int i = 0; i < RC; i++) mdl[i] = '0;
      end else begin
         for (int i = 0; i < RC; i++) nxt[i] = mdl[i];
         if (wr_enb) nxt[wr_addr] = wr_data;
         if (pr_enb) begin
            p   = int'(pr_addr);
            cur = {mdl[2*p], mdl[2*p+1]};
            case (pr_op)
               2'b00:   nw = pr_data;
               2'b01:   nw = cur + 16'd1;
               2'b10:   nw = cur - 16'd1;
               default: nw = cur;
            endcase
            nxt[2*p]   = nw[15:8];
            nxt[2*p+1] = nw[7:0];
         end
         for (int i = 0; i < RC; i++) mdl[i] = nxt[i];
      end
   endtask

   task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic pe, input logic [AW-2:0] pa, input logic [1:0] op,
                        input logic [2*DW-1:0] pd);
      @(negedge clk);
      rst     = r;
      wr_enb  = we;
      wr_addr = wa;
      wr_data = wd;
      pr_enb  = pe;
      pr_addr = pa;
      pr_op   = op;
      pr_data = pd;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      rst    = 1'b0;
      wr_enb = 1'b0;
      pr_enb = 1'b0;
   endtask

   task automatic pair_op(input logic [AW-2:0] pa, input logic [1:0] op, input logic [15:0] pd);
      drive(1'b0, 1'b0, '0, '0, 1'b1, pa, op, pd);
      step();
   endtask

   task automatic byte_wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      drive(1'b0, 1'b1, wa, wd, 1'b0, '0, 2'b11, '0);
      step();
   endtask

   initial begin
      logic [DW-1:0] old;
      rst = 1'b0; wr_enb = 1'b0; wr_addr = '0; wr_data = '0;
      pr_enb = 1'b0; pr_addr = '0; pr_op = 2'b11; pr_data = '0;
      rd_addr_a = '0; rd_addr_b = '0; rp_addr = '0;

      // Reset, then every address on every port reads zero.
      drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 2'b11, '0);
      step();
      for (int i = 0; i < RC; i++) begin
         push_val($sformatf("rst_a%0d", i), PORT_A, AW'(i), 16'h0000);
         push_val($sformatf("rst_b%0d", i), PORT_B, AW'(i), 16'h0000);
      end
      for (int p = 0; p < RC / 2; p++) push_val($sformatf("rst_p%0d", p), PORT_PAIR, AW'(p), 16'h0000);
      drain();

      // Byte writes assemble a pair.
      byte_wr(3'd2, 8'hAA);
      byte_wr(3'd3, 8'h55);
      push_val("byte_pair1", PORT_PAIR, 3'd1, 16'hAA55);
      push_val("byte_a3", PORT_A, 3'd3, 16'h0055);
      push_val("byte_b2", PORT_B, 3'd2, 16'h00AA);
      drain();

      // Carry from low into high byte, then full wrap in both directions.
      pair_op(2'd0, 2'b00, 16'h00FF);
      pair_op(2'd0, 2'b01, 16'h0000);
      push_val("inc_carry", PORT_PAIR, 3'd0, 16'h0100);
      drain();
      pair_op(2'd0, 2'b00, 16'hFFFF);
      pair_op(2'd0, 2'b01, 16'h0000);
      push_val("inc_wrap", PORT_PAIR, 3'd0, 16'h0000);
      drain();
      pair_op(2'd0, 2'b10, 16'h0000);
      push_val("dec_wrap", PORT_PAIR, 3'd0, 16'hFFFF);
      drain();
      pair_op(2'd0, 2'b11, 16'h1234);
      push_val("hold", PORT_PAIR, 3'd0, 16'hFFFF);
      push_val("hold_other", PORT_PAIR, 3'd1, 16'hAA55);
      drain();

      // Byte write and pair load on the same register: pair load wins.
      drive(1'b0, 1'b1, 3'd4, 8'h12, 1'b1, 2'd2, 2'b00, 16'h3456);
      step();
      push_val("prio_hi", PORT_A, 3'd4, 16'h0034);
      push_val("prio_lo", PORT_B, 3'd5, 16'h0056);
      drain();

      // Byte write and pair op on disjoint registers both land.
      drive(1'b0, 1'b1, 3'd7, 8'hC3, 1'b1, 2'd1, 2'b10, 16'h0000);
      step();
      push_val("both_byte", PORT_A, 3'd7, 16'h00C3);
      push_val("both_pair", PORT_PAIR, 3'd1, 16'hAA54);
      drain();

      // Same-cycle read of a register being written.
      old = mdl[1];
      drive(1'b0, 1'b1, 3'd1, 8'h77, 1'b0, '0, 2'b11, '0);
`ifdef REGFILE_BYPASS_EN
      push_val("fwd_same", PORT_A, 3'd1, 16'h0077);
`else
      push_val("fwd_same", PORT_A, 3'd1, {8'h00, old});
`endif
      drain();
      step();
      push_val("fwd_after", PORT_A, 3'd1, 16'h0077);
      drain();

      // Reset together with an increment discards the increment.
      pair_op(2'd3, 2'b00, 16'h1234);
      push_val("p3_load", PORT_PAIR, 3'd3, 16'h1234);
      drain();
      drive(1'b1, 1'b1, 3'd0, 8'h99, 1'b1, 2'd3, 2'b01, 16'h0000);
`ifdef REGFILE_BYPASS_EN
      push_val("rst_fwd", PORT_PAIR, 3'd3, 16'h0000);
`else
      push_val("rst_fwd", PORT_PAIR, 3'd3, 16'h1234);
`endif
      drain();
      step();
      for (int p = 0; p < RC / 2; p++) push_val($sformatf("rst_mid_p%0d", p), PORT_PAIR, AW'(p), 16'h0000);
      drain();

      // Randomised mixture checked against the model.
      for (int n = 0; n < 60; n++) begin
         drive(($urandom_range(0, 19) == 0), 1'($urandom), AW'($urandom), DW'($urandom),
               1'($urandom), (AW-1)'($urandom), 2'($urandom), 16'($urandom));
         if (($urandom_range(0, 3) == 0) && pr_enb) pr_data = 16'hFFFF;
         step();
         push_mdl($sformatf("rnd%0d_a", n), PORT_A, AW'($urandom));
         push_mdl($sformatf("rnd%0d_b", n), PORT_B, AW'($urandom));
         push_mdl($sformatf("rnd%0d_p", n), PORT_PAIR, AW'($urandom_range(0, RC / 2 - 1)));
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001: Parameter DATASIZE, default 8, register width in bits; SHALL be a multiple of 4.
REQ-002: Parameter REGCOUNT, default 8, number of registers; SHALL be an even power of two, minimum 2.
REQ-003: Parameter ADDRSIZE, default 3, register address width; SHALL equal log2(REGCOUNT).
REQ-004: clk  input  1  single clock; all state changes on rising edge.
REQ-005: rst  input  1  reset, synchronous, active-high.
REQ-006: wr_enb  input  1  byte write enable.
REQ-007: wr_addr  input  ADDRSIZE  byte write register index.
REQ-008: wr_data  input  DATASIZE  byte write data.
REQ-009: pr_enb  input  1  pair operation enable.
REQ-010: pr_addr  input  ADDRSIZE-1  pair index p, pair = reg[2p] (high) : reg[2p+1] (low).
REQ-011: pr_op  input  2  pair operation: 00 load, 01 increment, 10 decrement, 11 hold.
REQ-012: pr_data  input  2*DATASIZE  pair load data.
REQ-013: rd_addr_a / rd_addr_b  input  ADDRSIZE  byte read indices, ports A and B.
REQ-014: rd_data_a / rd_data_b  output  DATASIZE  byte read data, ports A and B.
REQ-015: rp_addr  input  ADDRSIZE-1  pair read index.
REQ-016: rp_data  output  2*DATASIZE  pair read data, {reg[2p], reg[2p+1]}.

Function
REQ-017: Storage SHALL be REGCOUNT registers of DATASIZE bits, updated only on rising clk.
REQ-018: Read ports SHALL be combinational from current storage; zero-cycle read latency.
REQ-019: wr_enb=1 SHALL write wr_data to reg[wr_addr] at the next edge; write latency 1 cycle.
REQ-020: pr_enb=1, pr_op=00 SHALL write pr_data high half to reg[2p], low half to reg[2p+1].
REQ-021: pr_op=01 SHALL write pair+1 modulo 2^(2*DATASIZE); 0xFFFF -> 0x0000 at DATASIZE=8.
REQ-022: pr_op=10 SHALL write pair-1 modulo 2^(2*DATASIZE); 0x0000 -> 0xFFFF at DATASIZE=8.
REQ-023: pr_op=11 SHALL leave the pair unchanged.
REQ-024: Carry/borrow SHALL propagate from low register into high register in the same cycle.
REQ-025: Simultaneous byte write and pair operation on different registers SHALL both take effect.
REQ-026: Simultaneous byte write to a register inside the addressed pair: pair operation SHALL win for that register.
REQ-027: No operation enabled SHALL hold all registers.

Reset
REQ-028: rst=1 at a rising edge SHALL clear every register to zero.
REQ-029: rst SHALL take priority over wr_enb and pr_enb in the same cycle; pending writes discarded.
REQ-030: rst asserted mid-sequence (between consecutive inc/dec) SHALL leave all pairs at zero afterwards.
REQ-031: After reset, rd_data_a, rd_data_b and rp_data SHALL read zero for any address.

Configuration
REQ-032: Macro REGFILE_BYPASS_EN SHALL enable write-to-read forwarding.
REQ-033: Defined: read ports SHALL return the value that will be written at the next edge (byte write or pair result, after REQ-026 priority) when the read address matches; rst=1 forces forwarded value to zero.
REQ-034: Undefined: read ports SHALL return stored contents only; new value visible the cycle after the write.

Verification
REQ-035: rst 1 cycle, then read all addresses on A, B, pair -> all zero.
REQ-036: byte write reg[2]=0xAA, reg[3]=0x55; read rp_addr=1 -> rp_data=0xAA55; rd_addr_a=3 -> 0x55.
REQ-037: pair load p=0 with 0x00FF, pr_op=01 -> 0x0100; load 0xFFFF, increment -> 0x0000; decrement -> 0xFFFF.
REQ-038: same cycle wr_enb reg[4]=0x12 and pair load p=2 with 0x3456 -> reg[4]=0x34, reg[5]=0x56.
REQ-039: wr_enb reg[1]=0x77 with rd_addr_a=1 in same cycle -> 0x77 same cycle with REGFILE_BYPASS_EN, old value without.
REQ-040: load p=3 with 0x1234, assert rst with pr_op=01 same cycle -> pair reads 0x0000 next cycle.
